// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Moore outputs decoded from the state register; pcEn folds in the same-cycle zero flag.
// Optional ADDI support is enabled by defining MULTICYCLE_CONTROL_ADDI_EN.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pcEn,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOP,
    output logic [1:0] pcSource,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;
    logic   decode_legal;
    logic   pcWrite, pcWriteCond;

    always_comb begin
        state_d      = FETCH;
        decode_legal = 1'b1;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = MEM_ADR;
                else if (opcode == OP_RTYPE)            state_d = EXECUTE;
                else if (opcode == OP_BEQ)              state_d = BRANCH;
                else if (opcode == OP_J)                state_d = JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
                else if (opcode == OP_ADDI)             state_d = ADDI_EX;
`endif
                else                                    decode_legal = 1'b0;
            end
            // Opcode is still stable here; anything other than lw/sw is aborted.
            MEM_ADR: begin
                if (opcode == OP_LW)      state_d = MEM_READ;
                else if (opcode == OP_SW) state_d = MEM_WRITE;
                else                      state_d = FETCH;
            end
            MEM_READ: state_d = MEM_WB;
            EXECUTE:  state_d = ALU_WB;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            ADDI_EX:  state_d = ADDI_WB;
`endif
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOP       = 2'b00;
        pcSource    = 2'b00;
        illegalOp   = 1'b0;
        case (state_q)
            FETCH: begin
                memRead = 1'b1;
                irWrite = 1'b1;
                pcWrite = 1'b1;
                aluSrcB = 2'b01;
            end
            DECODE: begin
                aluSrcB   = 2'b11;
                illegalOp = ~decode_legal;
            end
            MEM_ADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            EXECUTE: begin
                aluSrcA = 1'b1;
                aluOP   = 2'b10;
            end
            ALU_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOP       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            ADDI_EX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            ADDI_WB: regWrite = 1'b1;
`endif
            default: ;
        endcase
        // Reset blanks every strobe so nothing is written while the FSM restarts.
        if (reset) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            iorD        = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            irWrite     = 1'b0;
            memToReg    = 1'b0;
            regDst      = 1'b0;
            regWrite    = 1'b0;
            aluSrcA     = 1'b0;
            aluSrcB     = 2'b00;
            aluOP       = 2'b00;
            pcSource    = 2'b00;
            illegalOp   = 1'b0;
        end
    end

    assign pcEn  = pcWrite | (pcWriteCond & zero);
    assign state = reset ? 4'd0 : state_q;

endmodule
